// File: rtl/alu_control_md.sv
// alu_control_md: EX-stage ALU select decode plus an iterative
// multiply/divide sequencer owning the HI/LO registers.
module alu_control_md #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       ALU_Op,
   input  logic [5:0]       Funct,
   input  logic             Valid,
   input  logic [WIDTH-1:0] Rs_Data,
   input  logic [WIDTH-1:0] Rt_Data,
   output logic [3:0]       ALU_Sel,
   output logic             Stall,
   output logic             Md_Busy,
   output logic [WIDTH-1:0] Md_Data,
   output logic             Md_Read
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FIX} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [WIDTH-1:0]   opb_q;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;       // {upper, lower} working register
   logic               op_div_q, neg_res_q, neg_rem_q, div0_q;

   logic               is_special, md_start, rd_hi, rd_lo, wr_hi, wr_lo, issue;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_add;
   logic [WIDTH:0]     div_rem_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem_new;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // ALU operation select from op class and funct
   always_comb begin
      ALU_Sel = 4'h0;
      case (ALU_Op)
         3'b000:  ALU_Sel = 4'h0;
         3'b001:  ALU_Sel = 4'h1;
         3'b011:  ALU_Sel = 4'h0;
         3'b100:  ALU_Sel = 4'h6;
         3'b101:  ALU_Sel = 4'h2;
         3'b110:  ALU_Sel = 4'h3;
         3'b111:  ALU_Sel = 4'h4;
         3'b010: begin
            case (Funct)
               6'h20, 6'h21: ALU_Sel = 4'h0;
               6'h22, 6'h23: ALU_Sel = 4'h1;
               6'h24:        ALU_Sel = 4'h2;
               6'h25:        ALU_Sel = 4'h3;
               6'h26:        ALU_Sel = 4'h4;
               6'h27:        ALU_Sel = 4'h5;
               6'h2A:        ALU_Sel = 4'h6;
               6'h2B:        ALU_Sel = 4'h7;
               6'h00:        ALU_Sel = 4'h8;
               6'h02:        ALU_Sel = 4'h9;
               6'h03:        ALU_Sel = 4'hA;
               default:      ALU_Sel = 4'h0;
            endcase
         end
         default: ALU_Sel = 4'h0;
      endcase
   end

   // md instruction classification, issue and pipeline handshake outputs
   always_comb begin
      is_special = (ALU_Op == 3'b010);
      md_start   = is_special && (Funct == 6'h18 || Funct == 6'h19 ||
                                  Funct == 6'h1A || Funct == 6'h1B);
      rd_hi      = is_special && (Funct == 6'h10);
      rd_lo      = is_special && (Funct == 6'h12);
      wr_hi      = is_special && (Funct == 6'h11);
      wr_lo      = is_special && (Funct == 6'h13);
      issue      = Valid && md_start && (state_q == ST_IDLE) && rst_n;
      Stall      = issue || (state_q == ST_BUSY);
      Md_Busy    = (state_q != ST_IDLE);
      Md_Read    = Valid && (rd_hi || rd_lo) && (state_q == ST_IDLE) && rst_n;
      Md_Data    = rd_hi ? hi_q : (rd_lo ? lo_q : '0);
   end

   // operand magnitudes; Funct[0] clear marks the signed variants
   always_comb begin
      a_neg = !Funct[0] && Rs_Data[WIDTH-1];
      b_neg = !Funct[0] && Rt_Data[WIDTH-1];
      mag_a = a_neg ? -Rs_Data : Rs_Data;
      mag_b = b_neg ? -Rt_Data : Rt_Data;
   end

   // one shift-add or restoring-divide step, plus final sign correction
   always_comb begin
      mul_add     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge      = (div_rem_sh >= {1'b0, opb_q});
      // result is below the divisor when subtracting, so WIDTH bits suffice
      div_rem_new = div_ge ? (div_rem_sh[WIDTH-1:0] - opb_q) : div_rem_sh[WIDTH-1:0];
      acc_d       = op_div_q ? {div_rem_new, acc_q[WIDTH-2:0], div_ge}
                             : {mul_add, acc_q[WIDTH-1:1]};
      prod_fix    = neg_res_q ? -acc_q : acc_q;
      // with a zero divisor the remainder ends up equal to |dividend|,
      // so re-applying the dividend sign restores the raw Rs value
      rem_fix     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      quo_fix     = div0_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
   end

   // sequencer FSM, operand registers and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         op_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  op_div_q  <= Funct[1];
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  div0_q    <= Funct[1] && (Rt_Data == '0);
                  opb_q     <= Funct[1] ? mag_b : mag_a;
                  acc_q     <= {{WIDTH{1'b0}}, (Funct[1] ? mag_a : mag_b)};
                  cnt_q     <= '0;
                  state_q   <= ST_BUSY;
               end else if (Valid && wr_hi) begin
                  hi_q <= Rs_Data;
               end else if (Valid && wr_lo) begin
                  lo_q <= Rs_Data;
               end
            end
            ST_BUSY: begin
               acc_q <= acc_d;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_FIX: begin
               if (op_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Next-generation ALU control for the MIPS datapath.
- Decodes ALU_Op/Funct into a widened 4-bit ALU select covering the full R-type and I-type ALU set.
- Adds an iterative multiply/divide sequencer with HI/LO registers, plus a Stall output that freezes the pipeline while a mult/div executes in EX.
- Sits beside the main ALU in the EX stage.

Parameters:
- WIDTH, 32, datapath width; sets the operand, HI/LO width and iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- ALU_Op  input  3  op class from control unit
- Funct  input  6  instruction funct field
- Valid  input  1  EX-stage instruction is valid
- Rs_Data  input  WIDTH  rs operand (multiplicand / dividend / mthi, mtlo source)
- Rt_Data  input  WIDTH  rt operand (multiplier / divisor)
- ALU_Sel  output  4  ALU operation select (combinational)
- Stall  output  1  hold PC, IF/ID and ID/EX this cycle
- Md_Busy  output  1  sequencer is not IDLE
- Md_Data  output  WIDTH  HI for mfhi, LO for mflo, else 0 (combinational from registers)
- Md_Read  output  1  current EX instruction is a valid mfhi/mflo; selects Md_Data into the writeback path

Behaviour:
- ALU_Sel codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, A sra.
- ALU_Op decode:
  - 000 → add; 001 → sub; 011 → add.
  - 100 (slti) → slt; 101 (andi) → and; 110 (ori) → or; 111 (xori) → xor.
  - 010 decodes Funct:
    - 20/21 → add; 22/23 → sub; 24 → and; 25 → or; 26 → xor; 27 → nor.
    - 2A → slt; 2B → sltu; 00 → sll; 02 → srl; 03 → sra.
    - Any other funct → add.
- ALU_Sel is purely combinational and is independent of Valid and state.
- MD op classes, all requiring ALU_Op=010:
  - 18 mult, 19 multu, 1A div, 1B divu are "md start" ops.
  - 10 mfhi, 12 mflo are reads.
  - 11 mthi, 13 mtlo are writes.
- FSM states: IDLE, BUSY, FIX.
- Issue = Valid & md start & state==IDLE & rst_n.
- Stall = Issue | (state==BUSY). Stall is 0 in IDLE without issue and 0 in FIX.
- Md_Busy = (state != IDLE).
- IDLE:
  - On Issue, latch operands into internal registers: magnitudes for signed ops, raw values for unsigned.
  - Record the result sign flags, clear the counter, go to BUSY.
- BUSY: one iteration per cycle.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter increments each cycle; when counter==WIDTH-1, go to FIX.
- FIX (one cycle): apply sign correction and write HI/LO at the end of the cycle, then go to IDLE. Stall is low, so the md instruction leaves EX on the same edge.
- Stall timing: high for exactly WIDTH+1 consecutive cycles, starting on the issue cycle. HI/LO become visible on the cycle WIDTH+2 after issue, which is exactly when the next instruction occupies EX.
- Results:
  - mult/multu: {HI,LO} = full 2*WIDTH-bit product; signed result is negated when the operand signs differ.
  - div/divu: LO = quotient, HI = remainder. Signed quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - Signed MIN / -1 gives LO=MIN, HI=0, with no trap.
- Divide by zero (signed or unsigned): same latency; LO = all ones, HI = Rs_Data.
- mthi/mtlo: when Valid & state==IDLE, write Rs_Data into HI or LO on the clock edge. Single cycle, no stall.
- mfhi/mflo: Md_Read = Valid & decode & state==IDLE. Md_Data = HI or LO register value.
- A mthi/mtlo and a mfhi/mflo cannot coexist in EX, so no read/write conflict exists.
- Md instruction ignored when Valid=0, or when ALU_Op≠010 even if Funct matches.
- Reset (async, any state, including mid-operation):
  - state=IDLE, counter=0, HI=0, LO=0, all internal operand registers 0.
  - Stall, Md_Busy and Md_Read read 0 while rst_n=0.
  - An aborted md op leaves no result.
- Counter never exceeds WIDTH-1; no wrap.

Test Plan:
- Decode sweep: ALU_Op=010 with Funct=2A → ALU_Sel=6; Funct=27 → 5; Funct=3F → 0. ALU_Op=100 → 6; ALU_Op=110 → 3. Stall stays 0 throughout.
- mult, Rs=7, Rt=FFFFFFFD (WIDTH=32): Stall high exactly 33 cycles from issue, then HI=FFFFFFFF, LO=FFFFFFEB. Following mfhi/mflo return these values with Md_Read=1.
- multu, Rs=Rt=FFFFFFFF → HI=FFFFFFFE, LO=00000001. Signed div, Rs=FFFFFFF9 (-7), Rt=2 → LO=FFFFFFFD, HI=FFFFFFFF.
- divu, Rs=12345678, Rt=0 → LO=FFFFFFFF, HI=12345678 after 33 stall cycles. Signed div 80000000 / FFFFFFFF → LO=80000000, HI=0.
- mthi with Rs=A5A5A5A5, then mtlo with Rs=5A5A5A5A, no stall → mfhi returns A5A5A5A5, mflo returns 5A5A5A5A. The same ops with Valid=0 leave HI/LO unchanged.
- Assert rst_n low at BUSY iteration 10 of a mult: Stall and Md_Busy drop immediately, HI=LO=0. After release with Valid=0, state stays IDLE. A fresh mult 3×4 then completes with LO=C, HI=0.
